// File: rtl/clk_ctrl_pkg.sv
// rtl/clk_ctrl_pkg.sv - shared state encodings and defaults for the CPU clock-enable controller
//
// Purpose : FSM state type used by cpu_clock_ctrl (also the value driven on `mode`)
//           and the default debounce length for the button/switch conditioners.
// Contents: clk_state_t (ST_IDLE=00, ST_RUN=01, ST_STEP_WAIT=10, ST_HALTED=11),
//           DEFAULT_DEBOUNCE_CYCLES (10 ms at 100 MHz).

package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUN       = 2'b01,
        ST_STEP_WAIT = 2'b10,
        ST_HALTED    = 2'b11
    } clk_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

endpackage

// File: rtl/cpu_clock_ctrl_debounce.sv
// rtl/cpu_clock_ctrl_debounce.sv - 2-FF synchronizer followed by a counting debouncer
//
// Purpose : brings an asynchronous, bouncy level into the i_clock domain and only
//           accepts a change once it has been stable for DEBOUNCE_CYCLES cycles.
// Ports   : i_clock  system clock
//           i_reset  synchronous active-high reset (clears sync, counter, output)
//           i_raw    raw asynchronous input
//           o_level  debounced level
// Params  : DEBOUNCE_CYCLES  consecutive differing cycles needed to flip o_level

module debounce
    import clk_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any cycle where the synchronized input agrees with the output
            // (a bounce back) restarts the stability count.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// rtl/cpu_clock_ctrl.sv - converts the divider level into a one-cycle CPU clock enable
//
// Purpose : free-run / single-step / halt control of the RISC core clock enable,
//           with a running count of issued enables.
// Ports   : clock        system clock
//           reset        synchronous active-high reset
//           clk_div      divided clock level (same clock domain)
//           step_btn     raw push button (asynchronous, bouncy)
//           run_sw       raw slide switch, 1 = free-run (asynchronous)
//           halt         halt request from the core (level)
//           cpu_ce       registered one-cycle CPU enable
//           cycle_count  number of cpu_ce pulses issued (wraps)
//           mode         current FSM state encoding
//           halted       1 while in HALTED
// Params  : DEBOUNCE_CYCLES, CNT_W, BURST_LEN (BURST_LEN only with STEP_BURST_EN)
// Macro   : STEP_BURST_EN - each step press issues BURST_LEN enables instead of one.

module cpu_clock_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
`ifdef STEP_BURST_EN
    parameter int BURST_LEN       = 4,
`endif
    parameter int CNT_W           = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clk_div,
    input  logic             step_btn,
    input  logic             run_sw,
    input  logic             halt,
    output logic             cpu_ce,
    output logic [CNT_W-1:0] cycle_count,
    output logic [1:0]       mode,
    output logic             halted
);

    logic             r_clk_div_q;
    logic             w_tick;
    logic             w_step_db;
    logic             w_run_db;
    logic             r_step_db_q;
    logic             w_step_press;
    clk_state_t       r_state;
    clk_state_t       w_state_next;
    logic             r_cpu_ce;
    logic             w_ce_next;
    logic [CNT_W-1:0] r_cycle_count;

`ifdef STEP_BURST_EN
    localparam int BW = $clog2(BURST_LEN + 1);
    logic [BW-1:0] r_burst;
    logic [BW-1:0] w_burst_next;
`endif

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_step_db (
        .i_clock (clock),
        .i_reset (reset),
        .i_raw   (step_btn),
        .o_level (w_step_db)
    );

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_run_db (
        .i_clock (clock),
        .i_reset (reset),
        .i_raw   (run_sw),
        .o_level (w_run_db)
    );

    // Rising edge of the divider level: one tick per full clk_div period.
    assign w_tick       = clk_div & ~r_clk_div_q;
    assign w_step_press = w_step_db & ~r_step_db_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cpu_ce      <= 1'b0;
            r_cycle_count <= '0;
            r_clk_div_q   <= 1'b0;
            r_step_db_q   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cpu_ce    <= w_ce_next;
            r_clk_div_q <= clk_div;
            r_step_db_q <= w_step_db;
            if (r_cpu_ce) begin
                r_cycle_count <= r_cycle_count + CNT_W'(1);
            end
        end
    end

`ifdef STEP_BURST_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_burst <= '0;
        end else begin
            r_burst <= w_burst_next;
        end
    end
`endif

    always_comb begin
        w_state_next = r_state;
        w_ce_next    = 1'b0;
`ifdef STEP_BURST_EN
        w_burst_next = r_burst;
`endif
        case (r_state)
            ST_IDLE: begin
                if (halt) begin
                    w_state_next = ST_HALTED;
                end else if (w_run_db) begin
                    w_state_next = ST_RUN;
                end else if (w_step_press) begin
                    w_state_next = ST_STEP_WAIT;
`ifdef STEP_BURST_EN
                    w_burst_next = BW'(BURST_LEN);
`endif
                end
            end
            ST_RUN: begin
                if (halt) begin
                    w_state_next = ST_HALTED;
                end else begin
                    // A tick still counts in the cycle the switch is seen low.
                    w_ce_next = w_tick;
                    if (!w_run_db) begin
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_STEP_WAIT: begin
                if (halt) begin
                    w_state_next = ST_HALTED;
                end else if (w_tick) begin
                    w_ce_next = 1'b1;
`ifdef STEP_BURST_EN
                    w_burst_next = r_burst - BW'(1);
                    if (r_burst <= BW'(1)) begin
                        w_state_next = ST_IDLE;
                    end
`else
                    w_state_next = ST_IDLE;
`endif
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
        endcase
    end

    assign cpu_ce      = r_cpu_ce;
    assign cycle_count = r_cycle_count;
    assign mode        = r_state;
    assign halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb/tb_cpu_clock_ctrl.sv - directed self-checking bench for cpu_clock_ctrl

module tb_cpu_clock_ctrl;

`ifdef STEP_BURST_EN
    localparam int STEP_PULSES = 4;
`else
    localparam int STEP_PULSES = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clk_div = 1'b0;
    logic       step_btn = 1'b0;
    logic       run_sw = 1'b0;
    logic       halt = 1'b0;
    wire        cpu_ce;
    wire [3:0]  cycle_count;
    wire [1:0]  mode;
    wire        halted;

    logic       s_ce;
    logic [3:0] s_count;
    logic [1:0] s_mode;
    logic       s_halted;
    logic       prev_div = 1'b0;
    logic       pend_tick = 1'b0;
    logic       div_run = 1'b1;
    logic [1:0] div_phase = 2'd0;
    logic [3:0] exp_count = 4'd0;
    int         checks = 0;
    int         errors = 0;

    cpu_clock_ctrl #(
        .DEBOUNCE_CYCLES (4),
`ifdef STEP_BURST_EN
        .BURST_LEN       (4),
`endif
        .CNT_W           (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .clk_div     (clk_div),
        .step_btn    (step_btn),
        .run_sw      (run_sw),
        .halt        (halt),
        .cpu_ce      (cpu_ce),
        .cycle_count (cycle_count),
        .mode        (mode),
        .halted      (halted)
    );

    always #5 clock = ~clock;

    // Sample what the last posedge produced, then advance the ratio-2 divider.
    task automatic cyc();
        @(negedge clock);
        s_ce     = cpu_ce;
        s_count  = cycle_count;
        s_mode   = mode;
        s_halted = halted;
        prev_div = clk_div;
        if (div_run) begin
            div_phase = div_phase + 2'd1;
            clk_div   = div_phase[1];
        end
        pend_tick = clk_div & ~prev_div;
    endtask

    task automatic freeze();
        div_run   = 1'b0;
        div_phase = 2'd0;
        clk_div   = 1'b0;
        pend_tick = 1'b0;
    endtask

    task automatic test_reset();
        bit found;
        reset = 1'b1; run_sw = 1'b1; step_btn = 1'b0; halt = 1'b0; div_run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks += 3;
            if (s_ce !== 1'b0) begin errors++; $display("FAIL reset_ce cyc %0d got %b want 0", i, s_ce); end
            if (s_count !== 4'd0) begin errors++; $display("FAIL reset_count cyc %0d got %0d want 0", i, s_count); end
            if (s_mode !== 2'b00) begin errors++; $display("FAIL reset_mode cyc %0d got %b want 00", i, s_mode); end
        end
        reset = 1'b0;
        exp_count = 4'd0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            checks++;
            if (s_ce !== 1'b0) begin errors++; $display("FAIL enter_run_ce cyc %0d got %b want 0", i, s_ce); end
            if (i <= 5) begin
                checks++;
                if (s_mode !== 2'b00) begin errors++; $display("FAIL enter_run_early cyc %0d got %b want 00", i, s_mode); end
            end
            if (s_mode === 2'b01) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL enter_run_timeout got %b want 01", s_mode); end
    endtask

    task automatic test_free_run();
        logic q;
        int   pulses;
        q = pend_tick;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            checks += 3;
            if (s_ce !== q) begin errors++; $display("FAIL run_ce cyc %0d got %b want %b", i, s_ce, q); end
            if (s_count !== exp_count) begin errors++; $display("FAIL run_count cyc %0d got %0d want %0d", i, s_count, exp_count); end
            if (s_mode !== 2'b01) begin errors++; $display("FAIL run_mode cyc %0d got %b want 01", i, s_mode); end
            if (s_ce === 1'b1) pulses++;
            if (q) exp_count = exp_count + 4'd1;
            q = pend_tick;
        end
        checks++;
        if (pulses != 10) begin errors++; $display("FAIL run_pulses got %0d want 10", pulses); end
        // Switch drop: 2 sync + 4 debounce cycles, then the FSM edge; ticks up to
        // and including that edge still issue enables.
        run_sw = 1'b0;
        for (int j = 0; j < 20; j++) begin
            cyc();
            checks += 3;
            if (s_ce !== q) begin errors++; $display("FAIL drop_ce cyc %0d got %b want %b", j, s_ce, q); end
            if (s_count !== exp_count) begin errors++; $display("FAIL drop_count cyc %0d got %0d want %0d", j, s_count, exp_count); end
            if (s_mode !== ((j < 6) ? 2'b01 : 2'b00)) begin errors++; $display("FAIL drop_mode cyc %0d got %b want %b", j, s_mode, (j < 6) ? 2'b01 : 2'b00); end
            if (q) exp_count = exp_count + 4'd1;
            q = pend_tick && (j < 6);
        end
    endtask

    task automatic test_step();
        bit   found;
        logic q;
        int   remaining;
        int   pulses;
        freeze();
        step_btn = 1'b1; cyc();
        step_btn = 1'b0; cyc();
        step_btn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            checks++;
            if (s_ce !== 1'b0) begin errors++; $display("FAIL step_wait_ce cyc %0d got %b want 0", i, s_ce); end
            if (s_mode === 2'b10) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL step_enter_timeout got %b want 10", s_mode); end
        // Release and press again while still waiting for a tick: must be ignored.
        for (int i = 0; i < 18; i++) begin
            step_btn = (i >= 8);
            cyc();
            checks += 2;
            if (s_ce !== 1'b0) begin errors++; $display("FAIL step_repress_ce cyc %0d got %b want 0", i, s_ce); end
            if (s_mode !== 2'b10) begin errors++; $display("FAIL step_repress_mode cyc %0d got %b want 10", i, s_mode); end
        end
        div_run = 1'b1;
        q = 1'b0;
        remaining = STEP_PULSES;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            cyc();
            checks += 3;
            if (s_ce !== q) begin errors++; $display("FAIL step_ce cyc %0d got %b want %b", i, s_ce, q); end
            if (s_count !== exp_count) begin errors++; $display("FAIL step_count cyc %0d got %0d want %0d", i, s_count, exp_count); end
            if (s_ce === 1'b1) pulses++;
            if (q) begin exp_count = exp_count + 4'd1; remaining--; end
            if (s_mode !== ((remaining > 0) ? 2'b10 : 2'b00)) begin errors++; $display("FAIL step_mode cyc %0d got %b want %b", i, s_mode, (remaining > 0) ? 2'b10 : 2'b00); end
            q = pend_tick && (remaining > 0);
        end
        checks++;
        if (pulses != STEP_PULSES) begin errors++; $display("FAIL step_pulses got %0d want %0d", pulses, STEP_PULSES); end
        step_btn = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (s_ce !== 1'b0) begin errors++; $display("FAIL step_release_ce cyc %0d got %b want 0", i, s_ce); end
        end
    endtask

    task automatic test_halt_priority();
        bit found;
        freeze();
        run_sw = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            checks++;
            if (s_ce !== 1'b0) begin errors++; $display("FAIL halt_enter_ce cyc %0d got %b want 0", i, s_ce); end
            if (s_mode === 2'b01) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL halt_enter_timeout got %b want 01", s_mode); end
        div_run = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            checks++;
            if (s_ce !== 1'b0) begin errors++; $display("FAIL halt_pre_ce cyc %0d got %b want 0", i, s_ce); end
            if (pend_tick) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL halt_tick_timeout got 0 want 1"); end
        halt = 1'b1;
        cyc();
        checks += 3;
        if (s_ce !== 1'b0) begin errors++; $display("FAIL halt_same_tick_ce got %b want 0", s_ce); end
        if (s_mode !== 2'b11) begin errors++; $display("FAIL halt_mode got %b want 11", s_mode); end
        if (s_halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b want 1", s_halted); end
        halt = 1'b0;
        for (int i = 0; i < 22; i++) begin
            run_sw = (i >= 10);
            cyc();
            checks += 3;
            if (s_ce !== 1'b0) begin errors++; $display("FAIL halt_hold_ce cyc %0d got %b want 0", i, s_ce); end
            if (s_mode !== 2'b11) begin errors++; $display("FAIL halt_hold_mode cyc %0d got %b want 11", i, s_mode); end
            if (s_halted !== 1'b1) begin errors++; $display("FAIL halt_hold_flag cyc %0d got %b want 1", i, s_halted); end
        end
        checks++;
        if (s_count !== exp_count) begin errors++; $display("FAIL halt_count got %0d want %0d", s_count, exp_count); end
        reset = 1'b1;
        freeze();
        cyc();
        cyc();
        reset = 1'b0;
        exp_count = 4'd0;
        checks += 3;
        if (s_mode !== 2'b00) begin errors++; $display("FAIL halt_reset_mode got %b want 00", s_mode); end
        if (s_halted !== 1'b0) begin errors++; $display("FAIL halt_reset_flag got %b want 0", s_halted); end
        if (s_count !== 4'd0) begin errors++; $display("FAIL halt_reset_count got %0d want 0", s_count); end
    endtask

    task automatic test_wrap();
        bit   found;
        logic q;
        int   pulses;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            checks++;
            if (s_ce !== 1'b0) begin errors++; $display("FAIL wrap_enter_ce cyc %0d got %b want 0", i, s_ce); end
            if (s_mode === 2'b01) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL wrap_enter_timeout got %b want 01", s_mode); end
        div_run = 1'b1;
        q = 1'b0;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            cyc();
            checks += 2;
            if (s_ce !== q) begin errors++; $display("FAIL wrap_ce cyc %0d got %b want %b", i, s_ce, q); end
            if (s_count !== exp_count) begin errors++; $display("FAIL wrap_count cyc %0d got %0d want %0d", i, s_count, exp_count); end
            if (q) begin
                exp_count = exp_count + 4'd1;
                pulses++;
            end else if (pulses == 16) begin
                break;
            end
            q = pend_tick;
        end
        checks += 2;
        if (pulses != 16) begin errors++; $display("FAIL wrap_pulses got %0d want 16", pulses); end
        if (s_count !== 4'd0) begin errors++; $display("FAIL wrap_final got %0d want 0", s_count); end
        freeze();
        run_sw = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            checks++;
            if (s_ce !== 1'b0) begin errors++; $display("FAIL wrap_exit_ce cyc %0d got %b want 0", i, s_ce); end
            if (s_mode === 2'b00) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL wrap_exit_timeout got %b want 00", s_mode); end
    endtask

`ifdef STEP_BURST_EN
    task automatic test_burst_halt();
        bit   found;
        bit   hreq;
        logic q;
        int   pulses;
        freeze();
        step_btn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            checks++;
            if (s_ce !== 1'b0) begin errors++; $display("FAIL burst_enter_ce cyc %0d got %b want 0", i, s_ce); end
            if (s_mode === 2'b10) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL burst_enter_timeout got %b want 10", s_mode); end
        div_run = 1'b1;
        q = 1'b0;
        hreq = 1'b0;
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            cyc();
            checks++;
            if (s_ce !== q) begin errors++; $display("FAIL burst_ce cyc %0d got %b want %b", i, s_ce, q); end
            if (s_ce === 1'b1) pulses++;
            if (q) exp_count = exp_count + 4'd1;
            if (hreq) begin
                checks += 2;
                if (s_mode !== 2'b11) begin errors++; $display("FAIL burst_halt_mode cyc %0d got %b want 11", i, s_mode); end
                if (s_halted !== 1'b1) begin errors++; $display("FAIL burst_halt_flag cyc %0d got %b want 1", i, s_halted); end
            end
            if (q && pulses == 2 && !hreq) begin
                halt = 1'b1;
                hreq = 1'b1;
            end
            q = pend_tick && !hreq;
        end
        checks += 2;
        if (pulses != 2) begin errors++; $display("FAIL burst_halt_pulses got %0d want 2", pulses); end
        if (s_count !== exp_count) begin errors++; $display("FAIL burst_halt_count got %0d want %0d", s_count, exp_count); end
        halt = 1'b0;
        step_btn = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_free_run();
        test_step();
        test_halt_priority();
        test_wrap();
`ifdef STEP_BURST_EN
        test_burst_halt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_clock_ctrl.md
Name: cpu_clock_ctrl

Overview:
- Consumes the level output `clk_div` of the board clock divider, which runs in the same `clock` domain.
- Converts it into a one-cycle CPU clock-enable `cpu_ce` that drives the pipelined RISC core.
- Supports three operating modes: free-run, single-step from a debounced push button, and halt on a request from the core.
- Keeps a running count of issued enables for display and debug.

Parameters:
- DEBOUNCE_CYCLES, 1000000, stable-input cycles required to accept a button/switch change (10 ms at 100 MHz).
- CNT_W, 32, width of `cycle_count`.
- BURST_LEN, 4, enables issued per step press; used only with STEP_BURST_EN.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- clk_div  in  1  divided clock level from the divider, synchronous to `clock`.
- step_btn  in  1  raw push button; asynchronous and bouncy.
- run_sw  in  1  raw slide switch, 1 = free-run; asynchronous.
- halt  in  1  halt request from the core, synchronous, level.
- cpu_ce  out  1  registered one-cycle CPU enable.
- cycle_count  out  CNT_W  number of `cpu_ce` pulses issued.
- mode  out  2  current FSM state encoding.
- halted  out  1  1 while in HALTED.

Behaviour:
- Reset values (synchronous `reset`): state IDLE, `cpu_ce`=0, `cycle_count`=0, `mode`=2'b00, `halted`=0, all synchronizer, debounce and edge registers 0.
- Tick generation: `clk_div_q` <= `clk_div` each cycle; `tick` = `clk_div` & ~`clk_div_q`. This gives one tick per full `clk_div` period.
- Input conditioning: `step_btn` and `run_sw` each pass through a 2-FF synchronizer, then a debouncer.
  - The debounced output changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - The debounce counter clears on any bounce back.
  - `step_press` = rising edge of the debounced `step_btn` (one cycle).
- FSM (`mode` encoding): IDLE=00, RUN=01, STEP_WAIT=10, HALTED=11.
  - IDLE:
    - `halt` -> HALTED.
    - else `run_db` -> RUN.
    - else `step_press` -> STEP_WAIT.
  - RUN:
    - `halt` -> HALTED.
    - else !`run_db` -> IDLE.
    - `tick` in RUN with no `halt` sets `cpu_ce` next cycle. This includes the cycle in which `run_db` falls.
  - STEP_WAIT:
    - `halt` -> HALTED.
    - on `tick`: set `cpu_ce` next cycle, then -> IDLE.
    - `step_press` and `run_db` are ignored while waiting.
  - HALTED: `cpu_ce` stays 0; exit only via `reset`.
- Priority within a cycle: `halt` > `tick`. A `tick` coinciding with `halt` produces no enable.
- Latency: `cpu_ce` is high exactly one `clock` cycle, in the cycle after the qualifying `tick`. It is never high in two consecutive cycles unless DIV ratio = 1 (tick every 2 cycles minimum, so impossible).
- `cycle_count` increments in the cycle `cpu_ce` is high, registered the following edge. It wraps from 2^CNT_W-1 to 0 silently.
- `reset` mid-step or mid-debounce aborts everything; a pending step is lost.

Optional Feature:
- Macro STEP_BURST_EN.
- Defined:
  - STEP_WAIT holds a burst counter loaded with BURST_LEN on `step_press`.
  - Each `tick` issues one `cpu_ce` and decrements the counter.
  - Return to IDLE after the tick that takes the counter 1->0.
  - `halt` mid-burst -> HALTED immediately; the remaining count is discarded.
- Undefined: exactly one enable per press; no burst counter logic or BURST_LEN use.

Decomposition:
- Shared package/header `clk_ctrl_pkg`:
  - state encodings `ST_IDLE`, `ST_RUN`, `ST_STEP_WAIT`, `ST_HALTED` (2 bits).
  - default DEBOUNCE_CYCLES constant.
- Sub-module `debounce` (2-FF sync + counter, parameter DEBOUNCE_CYCLES), instantiated twice: `step_btn`, `run_sw`.
- FSM, tick detect and counter live in the top module.

Test Plan:
- Divider/bench setup: divider ratio 2 (`clk_div` toggles every 2 cycles, tick every 4); bench DEBOUNCE_CYCLES=4.
- Reset: assert `reset` 3 cycles with `run_sw`=1 -> `cpu_ce`=0, `cycle_count`=0, `mode`=00 throughout; 4+2 cycles after release, `mode`=01.
- Free-run: `run_sw`=1 for 40 cycles after entering RUN -> `cpu_ce` pulses exactly 1 cycle after each `tick` (10 pulses), `cycle_count`=10; drop `run_sw` -> `mode`=00 after debounce, no further pulses.
- Single-step with bounce: `step_btn` toggles 1,0,1 on 3 cycles, then held 1 for 10 -> exactly one `step_press`, one `cpu_ce` on the next tick, `cycle_count`+1, `mode` returns 00; a second press during STEP_WAIT yields no extra pulse.
- Halt priority: in RUN, assert `halt` in the same cycle as `tick` -> no `cpu_ce`, `mode`=11, `halted`=1; deassert `halt` and toggle `run_sw` -> stays HALTED until `reset`.
- Wrap: CNT_W=4, run 16 enables -> `cycle_count` sequence ...14,15,0.
- With STEP_BURST_EN, BURST_LEN=4: one press -> exactly 4 `cpu_ce` pulses on 4 consecutive ticks, then IDLE; `halt` after the 2nd pulse -> 2 pulses total, HALTED.
